// File: rtl/my_dcm.sv
// my_dcm: synthesizable stand-in for an FPGA clock manager wrapper.
//
// Divides CLK_IN by DIVIDE to produce CLK_OUT1. CLK_OUT1 is high for HIGH_CYCLES input cycles
// of every output period. LOCKED rises on the LOCK_CYCLES-th rising edge after reset release
// and stays high until the next reset.
//
// Ports:
//   CLK_IN   - reference clock; all state updates on its rising edge
//   RESET    - synchronous, active-high reset
//   CLK_OUT1 - divided clock, driven straight from a flop
//   LOCKED   - high once CLK_OUT1 is considered stable
//
// Optional build macro MY_DCM_OUT_GATE_EN: when defined, the divider is held at phase 0 with
// CLK_OUT1 low until LOCKED is high, so no partial pulses appear before lock.

module my_dcm #(
  parameter int unsigned DIVIDE      = 2,
  parameter int unsigned HIGH_CYCLES = DIVIDE / 2,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic CLK_IN,
  input  logic RESET,
  output logic CLK_OUT1,
  output logic LOCKED
);

  localparam int unsigned CntW  = (DIVIDE > 2) ? $clog2(DIVIDE) : 1;
  localparam int unsigned LockW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;

  // Elaboration-time parameter checks.
  if (DIVIDE < 2) begin : g_bad_divide
    $error("my_dcm: DIVIDE must be >= 2");
  end
  if (HIGH_CYCLES < 1 || HIGH_CYCLES > DIVIDE - 1) begin : g_bad_high
    $error("my_dcm: HIGH_CYCLES must be in 1..DIVIDE-1");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("my_dcm: LOCK_CYCLES must be >= 1");
  end

  // Power-up values: the block runs from the first edge even without a reset.
  logic [CntW-1:0]  cnt_q    = '0;
  logic [LockW-1:0] lcnt_q   = '0;
  logic             out_q    = 1'b0;
  logic             locked_q = 1'b0;

  logic [CntW-1:0]  cnt_d;
  logic [LockW-1:0] lcnt_d;
  logic             out_d;
  logic             locked_d;

  always_comb begin
    cnt_d    = (32'(cnt_q) == DIVIDE - 1) ? '0 : cnt_q + CntW'(1);
    out_d    = (32'(cnt_q) < HIGH_CYCLES);
    lcnt_d   = (32'(lcnt_q) < LOCK_CYCLES) ? lcnt_q + LockW'(1) : lcnt_q;
    // Lock asserts on the edge that brings the count to LOCK_CYCLES.
    locked_d = locked_q || (32'(lcnt_q) + 32'd1 >= LOCK_CYCLES);
`ifdef MY_DCM_OUT_GATE_EN
    // Uses the registered lock, so the first high pulse lands one edge after LOCKED rises.
    if (!locked_q) begin
      cnt_d = '0;
      out_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      cnt_q    <= '0;
      lcnt_q   <= '0;
      out_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      lcnt_q   <= lcnt_d;
      out_q    <= out_d;
      locked_q <= locked_d;
    end
  end

  assign CLK_OUT1 = out_q;
  assign LOCKED   = locked_q;

endmodule

// File: tb/tb_my_dcm.sv
`timescale 1ns / 1ps

module tb_my_dcm;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic out0, lock0;  // DIVIDE=2, default HIGH, LOCK=16
  logic out1, lock1;  // DIVIDE=5, HIGH=2, LOCK=16
  logic out2, lock2;  // DIVIDE=3, default HIGH=1, LOCK=1

  int n_pass  = 0;
  int n_total = 0;

  // Edges since the last reset edge (or power-up), as seen by the reference model.
  int k = 0;

  always #20.833 clk = ~clk;

  my_dcm #(.DIVIDE(2)) u0 (
    .CLK_IN(clk), .RESET(rst), .CLK_OUT1(out0), .LOCKED(lock0)
  );
  my_dcm #(.DIVIDE(5), .HIGH_CYCLES(2), .LOCK_CYCLES(16)) u1 (
    .CLK_IN(clk), .RESET(rst), .CLK_OUT1(out1), .LOCKED(lock1)
  );
  my_dcm #(.DIVIDE(3), .LOCK_CYCLES(1)) u2 (
    .CLK_IN(clk), .RESET(rst), .CLK_OUT1(out2), .LOCKED(lock2)
  );

  task automatic check(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endtask

  // Output model: edge k (1-based) after release; period d, high h, lock after l edges.
  function automatic logic m_out(input int kk, input int d, input int h, input int l);
    if (kk == 0) return 1'b0;
`ifdef MY_DCM_OUT_GATE_EN
    if (kk <= l) return 1'b0;
    return ((kk - l - 1) % d) < h;
`else
    return ((kk - 1) % d) < h;
`endif
  endfunction

  function automatic logic m_lock(input int kk, input int l);
    return kk >= l;
  endfunction

  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("u0_out",  out0,  m_out(k, 2, 1, 16));
    check("u0_lock", lock0, m_lock(k, 16));
    check("u1_out",  out1,  m_out(k, 5, 2, 16));
    check("u1_lock", lock1, m_lock(k, 16));
    check("u2_out",  out2,  m_out(k, 3, 1, 1));
    check("u2_lock", lock2, m_lock(k, 1));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic rec0 [1:21];
  logic rec1 [1:21];
  logic rl0  [1:21];

  initial begin
    // Power-up state before any edge.
    #1;
    check("pwr_out0",  out0,  1'b0);
    check("pwr_lock0", lock0, 1'b0);

    // Free-running from power-up, then reset 100..200 ns.
    #99 rst = 1'b1;
    #5;
    check("rst_out0",  out0,  1'b0);
    check("rst_lock0", lock0, 1'b0);
    #95 rst = 1'b0;

    // Edge 1 after release; also covers LOCK_CYCLES=1.
    step(1);
    rec0[1] = out0; rec1[1] = out1; rl0[1] = lock0;
    check("lc1_lock2", lock2, 1'b1);
`ifdef MY_DCM_OUT_GATE_EN
    check("lc1_out2", out2, 1'b0);
    step(1);
    check("lc1_out2_e2", out2, 1'b1);
    rec0[2] = out0; rec1[2] = out1; rl0[2] = lock0;
`else
    check("lc1_out2", out2, 1'b1);
    step(1);
    check("lc1_out2_e2", out2, 1'b0);
    rec0[2] = out0; rec1[2] = out1; rl0[2] = lock0;
`endif
    for (int e = 3; e <= 21; e++) begin
      step(1);
      rec0[e] = out0; rec1[e] = out1; rl0[e] = lock0;
    end

    check("lock_e15", rl0[15], 1'b0);
    check("lock_e16", rl0[16], 1'b1);
`ifdef MY_DCM_OUT_GATE_EN
    check("gate_e1",  rec0[1],  1'b0);
    check("gate_e16", rec0[16], 1'b0);
    check("gate_e17", rec0[17], 1'b1);
    check("gate_e18", rec0[18], 1'b0);
    check("d5_e17", rec1[17], 1'b1);
    check("d5_e18", rec1[18], 1'b1);
    check("d5_e19", rec1[19], 1'b0);
    check("d5_e20", rec1[20], 1'b0);
    check("d5_e21", rec1[21], 1'b0);
`else
    check("d2_e1", rec0[1], 1'b1);
    check("d2_e2", rec0[2], 1'b0);
    check("d2_e3", rec0[3], 1'b1);
    check("d5_e1", rec1[1], 1'b1);
    check("d5_e2", rec1[2], 1'b1);
    check("d5_e3", rec1[3], 1'b0);
    check("d5_e4", rec1[4], 1'b0);
    check("d5_e5", rec1[5], 1'b0);
    check("d5_e6", rec1[6], 1'b1);
`endif

    // One-cycle reset pulse while CLK_OUT1=1 and LOCKED=1 (edge 21).
    check("pre_pulse_out0",  out0,  1'b1);
    check("pre_pulse_lock0", lock0, 1'b1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("pulse_out0",  out0,  1'b0);
    check("pulse_lock0", lock0, 1'b0);
    step(15);
    check("relock_e15", lock0, 1'b0);
    step(1);
    check("relock_e16", lock0, 1'b1);

    // Reset held across several edges keeps everything cleared.
    rst = 1'b1;
    step(4);
    check("hold_out0",  out0,  1'b0);
    check("hold_lock2", lock2, 1'b0);
    rst = 1'b0;
    step(25);

    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
